// File: rtl/pipeline_ctrl_types.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipeline_ctrl_types: shared types and defaults for pipeline control |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pipeline_ctrl_types;

    localparam int REG_W_DEF = 3;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_detect: load-use hazard between the EX load and ID operands |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hazard_detect
    import pipeline_ctrl_types::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dest,
    input  logic [REG_W-1:0] id_sr1,
    input  logic [REG_W-1:0] id_sr2,
    input  logic             id_use_sr1,
    input  logic             id_use_sr2,
    output logic             hazard
);

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = id_use_sr1 && (id_sr1 == ex_dest);
    assign w_hit2 = id_use_sr2 && (id_sr2 == ex_dest);
    assign hazard = ex_mem_read && (w_hit1 || w_hit2);

endmodule
`default_nettype wire

// File: rtl/stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stall_unit: memory-wait stall FSM, hazard/redirect controls, stall |
// | cycle counter. Revision: 1.0                                       |
// +--------------------------------------------------------------------+
module stall_unit
    import pipeline_ctrl_types::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_resp,
    input  logic             dcache_resp,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dest,
    input  logic [REG_W-1:0] id_sr1,
    input  logic [REG_W-1:0] id_sr2,
    input  logic             id_use_sr1,
    input  logic             id_use_sr2,
    input  logic             br_taken,
    output logic             stall,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             icache_read,
    output logic             dcache_read,
    output logic             dcache_write,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e           state_q, state_d;
    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic w_mem_op;
    logic w_i_req, w_d_req;
    logic w_i_ok, w_d_ok;
    logic w_hazard;
    logic w_redirect;
    logic w_bubble;

    assign w_mem_op = mem_read | mem_write;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_dest     (ex_dest),
        .id_sr1      (id_sr1),
        .id_sr2      (id_sr2),
        .id_use_sr1  (id_use_sr1),
        .id_use_sr2  (id_use_sr2),
        .hazard      (w_hazard)
    );

    // A port counts as satisfied once flagged or while its response arrives.
    always_comb begin
        state_d  = state_q;
        i_done_d = i_done_q;
        d_done_d = d_done_q;
        w_i_req  = 1'b1;
        w_d_req  = w_mem_op;
        w_i_ok   = icache_resp;
        w_d_ok   = dcache_resp | ~w_mem_op;
        case (state_q)
            RUN: begin
                if (!(w_i_ok && w_d_ok)) begin
                    state_d  = MEM_WAIT;
                    i_done_d = icache_resp;
                    d_done_d = dcache_resp | ~w_mem_op;
                end
            end
            MEM_WAIT: begin
                w_i_req = ~i_done_q;
                w_d_req = w_mem_op & ~d_done_q;
                w_i_ok  = i_done_q | icache_resp;
                w_d_ok  = d_done_q | dcache_resp | ~w_mem_op;
                if (w_i_ok && w_d_ok) begin
                    state_d  = RUN;
                    i_done_d = 1'b0;
                    d_done_d = 1'b0;
                end else begin
                    i_done_d = w_i_ok;
                    d_done_d = w_d_ok;
                end
            end
            default: begin
                state_d  = RUN;
                i_done_d = 1'b0;
                d_done_d = 1'b0;
            end
        endcase
    end

    // Every control is forced quiet while reset is held.
    assign stall        = ~rst & ~(w_i_ok & w_d_ok);
    assign icache_read  = ~rst & w_i_req;
    assign dcache_read  = ~rst & w_d_req & mem_read;
    assign dcache_write = ~rst & w_d_req & mem_write;

    assign w_redirect   = ~rst & br_taken & ~stall;
    assign w_bubble     = ~rst & w_hazard & ~stall & ~br_taken;

    assign flush_if_id  = w_redirect;
    assign flush_id_ex  = w_redirect;
    assign bubble_id_ex = w_bubble;
    assign load_pc      = ~rst & ~w_bubble;
    assign load_if_id   = ~rst & ~w_bubble;

    assign stall_cycles_d = stall_cycles_q + CNT_W'(stall);
    assign stall_cycles   = stall_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            i_done_q       <= 1'b0;
            d_done_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            i_done_q       <= i_done_d;
            d_done_q       <= d_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stall_unit: directed vectors with a queue-based output monitor  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_resp, dcache_resp, mem_read, mem_write;
    logic        ex_mem_read;
    logic [2:0]  ex_dest, id_sr1, id_sr2;
    logic        id_use_sr1, id_use_sr2, br_taken;
    logic        stall, load_pc, load_if_id, bubble_id_ex;
    logic        flush_if_id, flush_id_ex;
    logic        icache_read, dcache_read, dcache_write;
    logic [31:0] stall_cycles;

    logic [8:0]  act_ctrl;
    logic [8:0]  exp_ctrl_q[$];
    logic [31:0] exp_cnt_q[$];
    string       exp_nm_q[$];
    logic        drv_done = 1'b0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    stall_unit dut (
        .clk          (clk),
        .rst          (rst),
        .icache_resp  (icache_resp),
        .dcache_resp  (dcache_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ex_mem_read  (ex_mem_read),
        .ex_dest      (ex_dest),
        .id_sr1       (id_sr1),
        .id_sr2       (id_sr2),
        .id_use_sr1   (id_use_sr1),
        .id_use_sr2   (id_use_sr2),
        .br_taken     (br_taken),
        .stall        (stall),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .icache_read  (icache_read),
        .dcache_read  (dcache_read),
        .dcache_write (dcache_write),
        .stall_cycles (stall_cycles)
    );

    // {stall, load_pc, load_if_id, bubble, flush_if_id, flush_id_ex, icr, dcr, dcw}
    assign act_ctrl = {stall, load_pc, load_if_id, bubble_id_ex, flush_if_id,
                       flush_id_ex, icache_read, dcache_read, dcache_write};

    task automatic clr();
        rst = 1'b0; icache_resp = 1'b0; dcache_resp = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; ex_mem_read = 1'b0;
        ex_dest = 3'd0; id_sr1 = 3'd0; id_sr2 = 3'd0;
        id_use_sr1 = 1'b0; id_use_sr2 = 1'b0; br_taken = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [8:0] ec, input logic [31:0] ecnt);
        exp_ctrl_q.push_back(ec);
        exp_cnt_q.push_back(ecnt);
        exp_nm_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #2;
        mem_read = 1'b1;
        chk("reset", 9'b000000000, 32'd0);

        clr(); icache_resp = 1'b1;               chk("hit0", 9'b011000100, 32'd0);
        clr(); icache_resp = 1'b1;               chk("hit1", 9'b011000100, 32'd0);

        clr(); mem_read = 1'b1;                  chk("ld_c0", 9'b111000110, 32'd0);
        clr(); mem_read = 1'b1;                  chk("ld_c1", 9'b111000110, 32'd1);
        clr(); mem_read = 1'b1; icache_resp = 1; chk("ld_c2", 9'b111000110, 32'd2);
        clr(); mem_read = 1'b1;                  chk("ld_c3", 9'b111000010, 32'd3);
        clr(); mem_read = 1'b1;                  chk("ld_c4", 9'b111000010, 32'd4);
        clr(); mem_read = 1'b1; dcache_resp = 1; chk("ld_c5", 9'b011000010, 32'd5);
        clr(); icache_resp = 1'b1;               chk("ld_after", 9'b011000100, 32'd5);

        clr(); mem_write = 1'b1; icache_resp = 1'b1; dcache_resp = 1'b1;
        chk("st_hit", 9'b011000101, 32'd5);

        clr(); icache_resp = 1; ex_mem_read = 1; ex_dest = 3'd3; id_use_sr2 = 1; id_sr2 = 3'd3;
        chk("lu_sr2", 9'b000100100, 32'd5);
        clr(); icache_resp = 1;                  chk("lu_after", 9'b011000100, 32'd5);
        clr(); icache_resp = 1; ex_mem_read = 1; ex_dest = 3'd3; id_use_sr2 = 1; id_sr2 = 3'd2;
        chk("lu_miss", 9'b011000100, 32'd5);
        clr(); icache_resp = 1; ex_mem_read = 1; ex_dest = 3'd3; id_use_sr1 = 1; id_sr1 = 3'd3; id_sr2 = 3'd3;
        chk("lu_sr1", 9'b000100100, 32'd5);
        clr(); icache_resp = 1; ex_mem_read = 1; ex_dest = 3'd3; id_sr1 = 3'd5; id_use_sr1 = 1; id_sr2 = 3'd3;
        chk("lu_unused", 9'b011000100, 32'd5);

        clr(); icache_resp = 1; br_taken = 1; ex_mem_read = 1; ex_dest = 3'd3; id_use_sr2 = 1; id_sr2 = 3'd3;
        chk("br_lu", 9'b011011100, 32'd5);
        clr(); icache_resp = 1;                  chk("br_after", 9'b011000100, 32'd5);
        clr(); br_taken = 1;                     chk("br_stall", 9'b111000100, 32'd5);
        clr(); br_taken = 1; icache_resp = 1;    chk("br_release", 9'b011011100, 32'd6);

        clr(); mem_read = 1; icache_resp = 1;    chk("rw_c0", 9'b111000110, 32'd6);
        clr(); mem_read = 1;                     chk("rw_c1", 9'b111000010, 32'd7);
        clr(); mem_read = 1; rst = 1'b1;         chk("rw_rst", 9'b000000000, 32'd0);
        clr(); icache_resp = 1; dcache_resp = 1; chk("rw_late_d", 9'b011000100, 32'd0);
        clr(); icache_resp = 1;                  chk("rw_run", 9'b011000100, 32'd0);
        clr(); dcache_resp = 1;                  chk("rw_d_only", 9'b111000100, 32'd0);
        clr(); icache_resp = 1;                  chk("rw_i_done", 9'b011000100, 32'd1);

        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        clr();                                   chk("wrap_pre", 9'b111000100, 32'hFFFF_FFFF);
        clr(); icache_resp = 1;                  chk("wrap_post", 9'b011000100, 32'd0);
        clr(); icache_resp = 1;                  chk("wrap_hold", 9'b011000100, 32'd0);

        drv_done = 1'b1;
    end

    initial begin
        int          cyc;
        logic [8:0]  ec;
        logic [31:0] ecnt;
        string       nm;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_ctrl_q.size() > 0) begin
                ec   = exp_ctrl_q.pop_front();
                ecnt = exp_cnt_q.pop_front();
                nm   = exp_nm_q.pop_front();
                total++;
                if (act_ctrl !== ec) begin
                    bad++;
                    $display("FAIL %s ctrl: got %b want %b", nm, act_ctrl, ec);
                end
                total++;
                if (stall_cycles !== ecnt) begin
                    bad++;
                    $display("FAIL %s stall_cycles: got %0h want %0h", nm, stall_cycles, ecnt);
                end
            end else if (drv_done) begin
                break;
            end
            if (cyc > 2000) begin
                total++;
                bad++;
                $display("FAIL watchdog: got %0d cycles want <= 2000", cyc);
                break;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
